psg_tone_detector: RTL and testbench

PSG_TONE_DETECTOR -- requirements
Module: psg_tone_detector

---
 rtl/psg_tone_detector.sv | 133 +++++++++++++
 tb/tb_psg_tone_detector.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psg_tone_detector.sv
// psg_tone_detector: per-channel rising-edge period and peak-to-peak amplitude meter.
// Optional feature macro PSG_DET_TIMEOUT_EN: a channel whose period counter saturates enters SILENT.
module psg_tone_detector #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    res_n_i,
    input  logic                    clock_en_i,
    input  logic                    clear_i,
    input  logic [NUM_CH*WIDTH-1:0] sample_i,
    output logic [NUM_CH*CNT_W-1:0] period_o,
    output logic [NUM_CH*WIDTH-1:0] magnitude_o,
    output logic [NUM_CH-1:0]       done_o,
    output logic [NUM_CH-1:0]       silent_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        SILENT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        state_t           r_state,  w_state_nx;
        logic [CNT_W-1:0] r_cnt,    w_cnt_nx;
        logic [WIDTH-1:0] r_prev,   w_prev_nx;
        logic [WIDTH-1:0] r_max,    w_max_nx;
        logic [WIDTH-1:0] r_min,    w_min_nx;
        logic [CNT_W-1:0] r_period, w_period_nx;
        logic [WIDTH-1:0] r_mag,    w_mag_nx;
        logic             r_done,   w_done_nx;
        logic             r_silent, w_silent_nx;
        logic [WIDTH-1:0] w_sample;
        logic             w_edge;
        logic             w_cnt_sat;

        assign w_sample  = sample_i[k*WIDTH +: WIDTH];
        assign w_edge    = (w_sample > r_prev);
        assign w_cnt_sat = (r_cnt == CNT_MAX);

        always_ff @(posedge clk or negedge res_n_i) begin
            if (!res_n_i) begin
                r_state  <= IDLE;
                r_cnt    <= '0;
                r_prev   <= '0;
                r_max    <= '0;
                r_min    <= '0;
                r_period <= '0;
                r_mag    <= '0;
                r_done   <= 1'b0;
                r_silent <= 1'b0;
            end else begin
                r_state  <= w_state_nx;
                r_cnt    <= w_cnt_nx;
                r_prev   <= w_prev_nx;
                r_max    <= w_max_nx;
                r_min    <= w_min_nx;
                r_period <= w_period_nx;
                r_mag    <= w_mag_nx;
                r_done   <= w_done_nx;
                r_silent <= w_silent_nx;
            end
        end

        always_comb begin
            w_state_nx  = r_state;
            w_cnt_nx    = r_cnt;
            w_prev_nx   = r_prev;
            w_max_nx    = r_max;
            w_min_nx    = r_min;
            w_period_nx = r_period;
            w_mag_nx    = r_mag;
            w_done_nx   = 1'b0;
            w_silent_nx = r_silent;

            if (clear_i) begin
                // Clear wins over any edge on this tick; prev re-arms on the live sample.
                w_state_nx  = IDLE;
                w_cnt_nx    = '0;
                w_period_nx = '0;
                w_mag_nx    = '0;
                w_silent_nx = 1'b0;
                w_prev_nx   = w_sample;
            end else if (clock_en_i) begin
                w_prev_nx = w_sample;
                case (r_state)
                    IDLE, SILENT: begin
                        if (w_edge) begin
                            w_state_nx = MEASURE;
                            w_cnt_nx   = CNT_W'(1);
                            w_max_nx   = w_sample;
                            w_min_nx   = w_sample;
                        end
                    end
                    MEASURE: begin
                        if (w_edge) begin
                            w_period_nx = r_cnt;
                            w_mag_nx    = r_max - r_min;
                            w_done_nx   = 1'b1;
                            w_silent_nx = 1'b0;
                            w_cnt_nx    = CNT_W'(1);
                            w_max_nx    = w_sample;
                            w_min_nx    = w_sample;
`ifdef PSG_DET_TIMEOUT_EN
                        end else if (w_cnt_sat) begin
                            w_state_nx  = SILENT;
                            w_period_nx = '0;
                            w_mag_nx    = '0;
                            w_done_nx   = 1'b1;
                            w_silent_nx = 1'b1;
`endif
                        end else begin
                            w_cnt_nx = w_cnt_sat ? r_cnt : r_cnt + CNT_W'(1);
                            w_max_nx = (w_sample > r_max) ? w_sample : r_max;
                            w_min_nx = (w_sample < r_min) ? w_sample : r_min;
                        end
                    end
                    default: w_state_nx = IDLE;
                endcase
            end
        end

        assign period_o[k*CNT_W +: CNT_W]    = r_period;
        assign magnitude_o[k*WIDTH +: WIDTH] = r_mag;
        assign done_o[k]                     = r_done;
        assign silent_o[k]                   = r_silent;
    end

endmodule

// File: tb/tb_psg_tone_detector.sv
// Randomised and directed bench for psg_tone_detector against a tick-history reference model.
module tb_psg_tone_detector;
    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int CNT_W  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam int HL     = 1024;
`ifdef PSG_DET_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    res_n_i = 1'b1;
    logic                    clock_en_i = 1'b0;
    logic                    clear_i = 1'b0;
    logic [NUM_CH*WIDTH-1:0] sample_i = '0;
    logic [NUM_CH*CNT_W-1:0] period_o;
    logic [NUM_CH*WIDTH-1:0] magnitude_o;
    logic [NUM_CH-1:0]       done_o;
    logic [NUM_CH-1:0]       silent_o;

    always #5 clk = ~clk;

    psg_tone_detector #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .res_n_i    (res_n_i),
        .clock_en_i (clock_en_i),
        .clear_i    (clear_i),
        .sample_i   (sample_i),
        .period_o   (period_o),
        .magnitude_o(magnitude_o),
        .done_o     (done_o),
        .silent_o   (silent_o)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: per channel, the tick of the last rising edge and a sample history.
    bit m_meas [NUM_CH];
    int m_t0   [NUM_CH];
    int m_prev [NUM_CH];
    int hist   [NUM_CH][HL];
    int tk = 0;
    int e_per  [NUM_CH];
    int e_mag  [NUM_CH];
    bit e_done [NUM_CH];
    bit e_sil  [NUM_CH];
    int smp    [NUM_CH];
    int cfg_p  [NUM_CH];
    int cfg_a  [NUM_CH];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int span(input int k, input int a, input int b);
        int mx, mn, v;
        mx = hist[k][a % HL];
        mn = mx;
        for (int i = a; i < b; i++) begin
            v = hist[k][i % HL];
            if (v > mx) mx = v;
            if (v < mn) mn = v;
        end
        return mx - mn;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_meas[k] = 1'b0; m_prev[k] = 0;
            e_per[k] = 0; e_mag[k] = 0; e_done[k] = 1'b0; e_sil[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        int d;
        for (int k = 0; k < NUM_CH; k++) e_done[k] = 1'b0;
        if (clear_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                m_meas[k] = 1'b0; e_per[k] = 0; e_mag[k] = 0; e_sil[k] = 1'b0;
                m_prev[k] = smp[k];
            end
        end else if (clock_en_i) begin
            tk++;
            for (int k = 0; k < NUM_CH; k++) begin
                hist[k][tk % HL] = smp[k];
                if (smp[k] > m_prev[k]) begin
                    if (m_meas[k]) begin
                        d = tk - m_t0[k];
                        e_per[k]  = (d > CMAX) ? CMAX : d;
                        e_mag[k]  = span(k, m_t0[k], tk);
                        e_done[k] = 1'b1;
                        e_sil[k]  = 1'b0;
                    end
                    m_meas[k] = 1'b1;
                    m_t0[k]   = tk;
                end else if (m_meas[k] && TMO && (tk - m_t0[k] == CMAX)) begin
                    m_meas[k] = 1'b0;
                    e_per[k] = 0; e_mag[k] = 0; e_sil[k] = 1'b1; e_done[k] = 1'b1;
                end
                m_prev[k] = smp[k];
            end
        end
    endtask

    task automatic compare();
        logic [NUM_CH*CNT_W-1:0] xp;
        logic [NUM_CH*WIDTH-1:0] xm;
        logic [NUM_CH-1:0]       xd, xs;
        for (int k = 0; k < NUM_CH; k++) begin
            xp[k*CNT_W +: CNT_W] = CNT_W'(e_per[k]);
            xm[k*WIDTH +: WIDTH] = WIDTH'(e_mag[k]);
            xd[k] = e_done[k];
            xs[k] = e_sil[k];
        end
        chk("period", 64'(period_o), 64'(xp));
        chk("magnitude", 64'(magnitude_o), 64'(xm));
        chk("done", 64'(done_o), 64'(xd));
        chk("silent", 64'(silent_o), 64'(xs));
    endtask

    task automatic cycle();
        for (int k = 0; k < NUM_CH; k++) sample_i[k*WIDTH +: WIDTH] = WIDTH'(smp[k]);
        model_step();
        @(posedge clk); #1;
        compare();
    endtask

    task automatic pulse_reset();
        res_n_i = 1'b0;
        #1;
        chk("rst_period", 64'(period_o), 64'd0);
        chk("rst_magnitude", 64'(magnitude_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_silent", 64'(silent_o), 64'd0);
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        res_n_i = 1'b1;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        clock_en_i = 1'b1;
        for (int k = 0; k < NUM_CH; k++) smp[k] = 0;
        cycle();
        clear_i = 1'b0;
    endtask

    task automatic run_squares(input int ncyc, input int en_div);
        int ph [NUM_CH];
        int last [NUM_CH];
        for (int k = 0; k < NUM_CH; k++) begin ph[k] = 0; last[k] = -1; end
        for (int c = 0; c < ncyc; c++) begin
            clock_en_i = ((c % en_div) == 0);
            for (int k = 0; k < NUM_CH; k++)
                smp[k] = (cfg_p[k] == 0) ? 0 :
                         (((ph[k] % cfg_p[k]) < cfg_p[k] / 2) ? 0 : cfg_a[k]);
            cycle();
            for (int k = 0; k < NUM_CH; k++) begin
                if (done_o[k]) begin
                    chk("sq_period", 64'(period_o[k*CNT_W +: CNT_W]), 64'(cfg_p[k]));
                    chk("sq_magnitude", 64'(magnitude_o[k*WIDTH +: WIDTH]), 64'(cfg_a[k]));
                    if (last[k] >= 0) chk("sq_gap", 64'(c - last[k]), 64'(cfg_p[k] * en_div));
                    last[k] = c;
                end
            end
            if (clock_en_i) for (int k = 0; k < NUM_CH; k++) ph[k]++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        for (int k = 0; k < NUM_CH; k++) begin smp[k] = 0; cfg_p[k] = 0; cfg_a[k] = 0; end
        #2;
        pulse_reset();

        // Square 0/100 period 10 on ch0, full rate then every other clock.
        do_clear();
        cfg_p[0] = 10; cfg_a[0] = 100;
        run_squares(120, 1);
        do_clear();
        run_squares(240, 2);

        // Four distinct tones with coincident publishes.
        do_clear();
        for (int k = 0; k < NUM_CH; k++) begin cfg_p[k] = 4 + 2 * k; cfg_a[k] = 10 * (k + 1); end
        run_squares(260, 1);

        // Reset in the middle of a period, then resume the square on ch0.
        for (int k = 1; k < NUM_CH; k++) begin cfg_p[k] = 0; cfg_a[k] = 0; end
        do_clear();
        cfg_p[0] = 10; cfg_a[0] = 100;
        run_squares(27, 1);
        pulse_reset();
        run_squares(60, 1);

        // Clear on an edge tick: no publish, outputs zero, next edge only re-arms.
        do_clear();
        clock_en_i = 1'b1;
        smp[0] = 0; cycle();
        smp[0] = 100; cycle();
        smp[0] = 0; cycle(); cycle();
        smp[0] = 100; clear_i = 1'b1; cycle();
        clear_i = 1'b0;
        chk("clr_done", 64'(done_o), 64'd0);
        chk("clr_period", 64'(period_o), 64'd0);
        smp[0] = 0; cycle(); cycle();
        smp[0] = 100; cycle();
        chk("clr_rearm_done", 64'(done_o[0]), 64'd0);
        smp[0] = 0; cycle();
        smp[0] = 100; cycle();
        chk("clr_pub_done", 64'(done_o[0]), 64'd1);
        chk("clr_pub_period", 64'(period_o[CNT_W-1:0]), 64'd2);

        // Single edge on ch1 then a flat level long enough to saturate the counter.
        do_clear();
        ndone = 0;
        clock_en_i = 1'b1;
        for (int c = 0; c < 3; c++) cycle();
        smp[1] = 50;
        for (int c = 0; c < 300; c++) begin
            cycle();
            if (done_o[1]) ndone++;
        end
        chk("tmo_done_count", 64'(ndone), 64'(TMO ? 1 : 0));
        chk("tmo_silent", 64'(silent_o[1]), 64'(TMO));
        chk("tmo_period", 64'(period_o[2*CNT_W-1:CNT_W]), 64'd0);
        smp[1] = 60; cycle();
        chk("tmo_after_edge_done", 64'(done_o[1]), 64'(TMO ? 0 : 1));

        // Random samples, enables, clears and occasional resets.
        do_clear();
        for (int c = 0; c < 2500; c++) begin
            clock_en_i = ($urandom_range(0, 3) != 0);
            clear_i    = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < NUM_CH; k++)
                if ($urandom_range(0, 3) == 0) smp[k] = int'($urandom_range(0, 255));
            cycle();
            clear_i = 1'b0;
            if ($urandom_range(0, 599) == 0) pulse_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
